// File: rtl/bcd_timer_if.sv
// rtl/bcd_timer_if.sv - control and display bundle of the BCD timer
//
// Purpose : groups the timer's control strobes, preset bus and display
//           outputs so the core and its driver share one connection.
// Modports: master - drives clear/count_enabled/down/load/load_value/lap,
//                    observes time_reading/tc/lap_active
//           slave  - the timer core (opposite directions)
// Params  : DIGITS - number of BCD digits (bus width 4*DIGITS)

interface bcd_timer_if #(
  parameter int DIGITS = 2
);
  logic                  clear;
  logic                  count_enabled;
  logic                  down;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  lap;
  logic [4*DIGITS-1:0]   time_reading;
  logic                  tc;
  logic                  lap_active;

  modport master (
    output clear, count_enabled, down, load, load_value, lap,
    input  time_reading, tc, lap_active
  );

  modport slave (
    input  clear, count_enabled, down, load, load_value, lap,
    output time_reading, tc, lap_active
  );
endinterface

// File: rtl/bcd_timer.sv
// rtl/bcd_timer.sv - multi-digit BCD up/down timer with tick divider
//
// Purpose : divides clk by DIV = CLK_FREQ/TICK_HZ and advances a chain of
//           BCD digits up or down on each tick, with preset load, clear,
//           wrap-or-saturate terminal behaviour and a terminal-count pulse.
// Ports   : clk          - system clock, rising edge
//           init_regs_n  - asynchronous active-low reset
//           bus          - bcd_timer_if.slave: clear, count_enabled, down,
//                          load, load_value, lap in; time_reading, tc,
//                          lap_active out
// Params  : CLK_FREQ, TICK_HZ, DIGITS (1..8), MSD_LIMIT (2..10),
//           SATURATE (0 wrap, 1 hold at terminal count)
// Macro   : BCD_TIMER_LAP_EN - adds the lap register and frozen display;
//           without it lap is ignored and lap_active is tied low.

module bcd_timer #(
  parameter int CLK_FREQ  = 100000000,
  parameter int TICK_HZ   = 1,
  parameter int DIGITS    = 2,
  parameter int MSD_LIMIT = 10,
  parameter bit SATURATE  = 1'b0
) (
  input logic        clk,
  input logic        init_regs_n,
  bcd_timer_if.slave bus
);

  localparam int DIV   = CLK_FREQ / TICK_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam int W     = 4 * DIGITS;

  logic [DIV_W-1:0] div_q;
  logic [W-1:0]     digits_q;
  logic             tc_q;

  logic             tick;
  logic [W-1:0]     max_val;
  logic [W-1:0]     step_val;
  logic [W-1:0]     digits_next;
  logic [W-1:0]     load_clamped;
  logic             carry;
  logic             at_term;
  logic             step_term;
  logic             tc_next;

  // Highest legal value of digit idx: MSD_LIMIT-1 for the top digit, 9 below.
  function automatic logic [3:0] digit_max(input int idx);
    return (idx == DIGITS - 1) ? 4'(MSD_LIMIT - 1) : 4'd9;
  endfunction

  assign tick = bus.count_enabled && (div_q == DIV_LAST);

  always_comb begin
    max_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      max_val[4*i +: 4] = digit_max(i);
    end
  end

  // Ripple one step through the digit chain. carry doubles as borrow when
  // counting down; a fully carried chain yields the wrapped value.
  always_comb begin
    step_val = digits_q;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (!bus.down) begin
          if (digits_q[4*i +: 4] >= digit_max(i)) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (digits_q[4*i +: 4] == 4'd0) begin
            step_val[4*i +: 4] = digit_max(i);
          end else begin
            step_val[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
  end

  // Terminal count depends on direction: all-max going up, all-zero going down.
  assign at_term   = bus.down ? (digits_q == '0) : (digits_q == max_val);
  assign step_term = bus.down ? (step_val == '0) : (step_val == max_val);

  always_comb begin
    digits_next = step_val;
    tc_next     = 1'b0;
    if (SATURATE) begin
      // Hold once terminal; pulse only on the step that arrives there.
      if (at_term) begin
        digits_next = digits_q;
      end else begin
        tc_next = step_term;
      end
    end else begin
      // Wrapping: the pulse marks the wrap itself.
      tc_next = at_term;
    end
  end

  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_value[4*i +: 4] > digit_max(i)) begin
        load_clamped[4*i +: 4] = digit_max(i);
      end else begin
        load_clamped[4*i +: 4] = bus.load_value[4*i +: 4];
      end
    end
  end

  // clear beats load beats counting; a tick coinciding with either is lost.
  always_ff @(posedge clk or negedge init_regs_n) begin
    if (!init_regs_n) begin
      div_q    <= '0;
      digits_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.clear) begin
        div_q    <= '0;
        digits_q <= '0;
      end else if (bus.load) begin
        div_q    <= '0;
        digits_q <= load_clamped;
      end else if (bus.count_enabled) begin
        div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          digits_q <= digits_next;
          tc_q     <= tc_next;
        end
      end
    end
  end

  assign bus.tc = tc_q;

`ifdef BCD_TIMER_LAP_EN
  typedef enum logic {
    DISP_LIVE   = 1'b0,
    DISP_FROZEN = 1'b1
  } disp_state_t;

  disp_state_t state_q;
  disp_state_t state_d;
  logic [W-1:0] lap_q;
  logic         lap_capture;

  always_ff @(posedge clk or negedge init_regs_n) begin
    if (!init_regs_n) begin
      state_q <= DISP_LIVE;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (lap_capture) begin
        lap_q <= digits_q;
      end
    end
  end

  // Each lap strobe toggles frozen/live; clear always returns to live.
  // load leaves the frozen display alone.
  always_comb begin
    state_d     = state_q;
    lap_capture = 1'b0;
    if (bus.clear) begin
      state_d = DISP_LIVE;
    end else if (bus.lap) begin
      case (state_q)
        DISP_LIVE: begin
          state_d     = DISP_FROZEN;
          lap_capture = 1'b1;
        end
        default: begin
          state_d = DISP_LIVE;
        end
      endcase
    end
  end

  assign bus.lap_active   = (state_q == DISP_FROZEN);
  assign bus.time_reading = (state_q == DISP_FROZEN) ? lap_q : digits_q;
`else
  logic lap_unused;
  assign lap_unused       = bus.lap;
  assign bus.lap_active   = 1'b0;
  assign bus.time_reading = digits_q;
`endif

endmodule

// File: tb/tb_bcd_timer.sv
// tb/tb_bcd_timer.sv - directed self-checking bench for bcd_timer

module tb_bcd_timer;

  logic clk = 1'b0;
  logic init_regs_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   tc_cnt;

  always #5 clk = ~clk;

  bcd_timer_if #(.DIGITS(2)) bus_a ();
  bcd_timer_if #(.DIGITS(3)) bus_b ();
  bcd_timer_if #(.DIGITS(2)) bus_c ();

  bcd_timer #(.CLK_FREQ(10), .TICK_HZ(1), .DIGITS(2), .MSD_LIMIT(10), .SATURATE(1'b0))
    u_a (.clk(clk), .init_regs_n(init_regs_n), .bus(bus_a));
  bcd_timer #(.CLK_FREQ(10), .TICK_HZ(1), .DIGITS(3), .MSD_LIMIT(6), .SATURATE(1'b0))
    u_b (.clk(clk), .init_regs_n(init_regs_n), .bus(bus_b));
  bcd_timer #(.CLK_FREQ(10), .TICK_HZ(1), .DIGITS(2), .MSD_LIMIT(10), .SATURATE(1'b1))
    u_c (.clk(clk), .init_regs_n(init_regs_n), .bus(bus_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    bus_a.clear = 0; bus_a.count_enabled = 0; bus_a.down = 0;
    bus_a.load = 0; bus_a.load_value = '0; bus_a.lap = 0;
    bus_b.clear = 0; bus_b.count_enabled = 0; bus_b.down = 0;
    bus_b.load = 0; bus_b.load_value = '0; bus_b.lap = 0;
    bus_c.clear = 0; bus_c.count_enabled = 0; bus_c.down = 0;
    bus_c.load = 0; bus_c.load_value = '0; bus_c.lap = 0;

    #2;
    chk("rst_time", bus_a.time_reading, 8'h00);
    chk("rst_tc", bus_a.tc, 1'b0);
    chk("rst_lap", bus_a.lap_active, 1'b0);
    chk("rst_time_b", bus_b.time_reading, 12'h000);

    // Free-running up count: 00..99 then wrap with a single tc at edge 1000.
    step(2);
    init_regs_n = 1;
    bus_a.count_enabled = 1;
    tc_cnt = 0;
    for (int n = 1; n <= 1000; n++) begin
      step(1);
      chk("a_run", bus_a.time_reading, to_bcd2((n / 10) % 100));
      if (bus_a.tc) tc_cnt++;
      if (n == 999) chk("a_at99", bus_a.time_reading, 8'h99);
      if (n == 1000) chk("a_wrap_tc", bus_a.tc, 1'b1);
    end
    chk("a_tc_count", tc_cnt, 1);
    step(1);
    chk("a_tc_drop", bus_a.tc, 1'b0);
    bus_a.count_enabled = 0;

    // DIGITS=3, MSD_LIMIT=6: carry, terminal wrap both ways, borrow, clamp.
    bus_b.load_value = 12'h559; bus_b.load = 1; step(1); bus_b.load = 0;
    chk("b_load559", bus_b.time_reading, 12'h559);
    bus_b.count_enabled = 1;
    step(10);
    chk("b_560", bus_b.time_reading, 12'h560);
    chk("b_560_tc", bus_b.tc, 1'b0);
    bus_b.load_value = 12'h599; bus_b.load = 1; step(1); bus_b.load = 0;
    step(9);
    chk("b_599_hold", bus_b.time_reading, 12'h599);
    step(1);
    chk("b_up_wrap", bus_b.time_reading, 12'h000);
    chk("b_up_tc", bus_b.tc, 1'b1);
    bus_b.down = 1;
    step(1);
    chk("b_tc_drop", bus_b.tc, 1'b0);
    step(8);
    chk("b_000_hold", bus_b.time_reading, 12'h000);
    step(1);
    chk("b_dn_wrap", bus_b.time_reading, 12'h599);
    chk("b_dn_tc", bus_b.tc, 1'b1);
    bus_b.load_value = 12'h100; bus_b.load = 1; step(1); bus_b.load = 0;
    step(10);
    chk("b_borrow", bus_b.time_reading, 12'h099);
    chk("b_borrow_tc", bus_b.tc, 1'b0);
    bus_b.count_enabled = 0;
    bus_b.load_value = 12'h9AF; bus_b.load = 1; step(1); bus_b.load = 0;
    chk("b_clamp", bus_b.time_reading, 12'h599);

    // Saturating down count from 02.
    bus_c.down = 1;
    bus_c.load_value = 8'h02; bus_c.load = 1; step(1); bus_c.load = 0;
    bus_c.count_enabled = 1;
    tc_cnt = 0;
    for (int n = 1; n <= 50; n++) begin
      step(1);
      if (bus_c.tc) tc_cnt++;
      if (n == 10) begin
        chk("c_01", bus_c.time_reading, 8'h01);
        chk("c_01_tc", bus_c.tc, 1'b0);
      end
      if (n == 20) begin
        chk("c_00", bus_c.time_reading, 8'h00);
        chk("c_00_tc", bus_c.tc, 1'b1);
      end
    end
    chk("c_hold", bus_c.time_reading, 8'h00);
    chk("c_tc_count", tc_cnt, 1);
    bus_c.count_enabled = 0;

    // Enable gating freezes the divider without zeroing it.
    bus_a.clear = 1; step(1); bus_a.clear = 0;
    bus_a.count_enabled = 1;
    step(7);
    bus_a.count_enabled = 0;
    step(20);
    chk("a_frozen", bus_a.time_reading, 8'h00);
    bus_a.count_enabled = 1;
    step(2);
    chk("a_reen_2", bus_a.time_reading, 8'h00);
    step(1);
    chk("a_reen_3", bus_a.time_reading, 8'h01);
    // clear coinciding with a tick wins and suppresses tc.
    step(9);
    bus_a.clear = 1; step(1); bus_a.clear = 0;
    chk("a_clr_tick", bus_a.time_reading, 8'h00);
    chk("a_clr_tc", bus_a.tc, 1'b0);
    bus_a.load_value = 8'hAF; bus_a.load = 1; step(1); bus_a.load = 0;
    chk("a_clamp", bus_a.time_reading, 8'h99);
    step(9);
    chk("a_99_hold", bus_a.time_reading, 8'h99);
    step(1);
    chk("a_99_wrap", bus_a.time_reading, 8'h00);
    chk("a_99_tc", bus_a.tc, 1'b1);

    bus_a.clear = 1; step(1); bus_a.clear = 0;
    step(120);
    chk("a_at12", bus_a.time_reading, 8'h12);
    bus_a.lap = 1; step(1); bus_a.lap = 0;
`ifdef BCD_TIMER_LAP_EN
    chk("lap_on", bus_a.lap_active, 1'b1);
    chk("lap_frz12", bus_a.time_reading, 8'h12);
    step(29);
    chk("lap_still12", bus_a.time_reading, 8'h12);
    bus_a.lap = 1; step(1); bus_a.lap = 0;
    chk("lap_off", bus_a.lap_active, 1'b0);
    chk("lap_live15", bus_a.time_reading, 8'h15);
    bus_a.lap = 1; step(1); bus_a.lap = 0;
    bus_a.load_value = 8'h33; bus_a.load = 1; step(1); bus_a.load = 0;
    chk("lap_load_keep", bus_a.lap_active, 1'b1);
    chk("lap_load_frz", bus_a.time_reading, 8'h15);
    bus_a.clear = 1; step(1); bus_a.clear = 0;
    chk("lap_clr_drop", bus_a.lap_active, 1'b0);
    chk("lap_clr_time", bus_a.time_reading, 8'h00);
`else
    chk("nolap_active", bus_a.lap_active, 1'b0);
    chk("nolap_live", bus_a.time_reading, 8'h12);
`endif

    // Asynchronous reset in the middle of a count at 47.
    bus_a.load_value = 8'h46; bus_a.load = 1; step(1); bus_a.load = 0;
    step(10);
    chk("a_at47", bus_a.time_reading, 8'h47);
    #3;
    init_regs_n = 0;
    #1;
    chk("arst_time", bus_a.time_reading, 8'h00);
    chk("arst_tc", bus_a.tc, 1'b0);
    chk("arst_lap", bus_a.lap_active, 1'b0);
    step(1);
    init_regs_n = 1;
    step(9);
    chk("arst_9", bus_a.time_reading, 8'h00);
    step(1);
    chk("arst_10", bus_a.time_reading, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
